// File: rtl/obstacle_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_streamer_pkg
// Description : Obstacle type codes, FSM states and obstacle word layout
//               shared by the obstacle streamer and its row ring buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package obstacle_streamer_pkg;

  typedef enum logic [2:0] {
    EMPTY  = 3'b000,
    LOW    = 3'b001,
    HIGH   = 3'b010,
    MID    = 3'b011,
    TRAIN  = 3'b100,
    RAMP   = 3'b101,
    MOVING = 3'b110
  } obstacle_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    ADVANCE = 2'd2
  } state_e;

  localparam int RAMP_FIRST_OFFSET = 256;

  localparam int LANES      = 3;
  localparam int ENTRY_BITS = 4;
  localparam int ROW_BITS   = LANES * ENTRY_BITS;

  localparam int OBS_BITS       = 16;
  localparam int OBS_TYPE_LSB   = 13;
  localparam int OBS_TYPE_BITS  = 3;
  localparam int OBS_LANE_LSB   = 11;
  localparam int OBS_LANE_BITS  = 2;
  localparam int OBS_DEPTH_LSB  = 0;
  localparam int OBS_DEPTH_BITS = 11;

  function automatic logic [OBS_BITS-1:0] pack_obstacle(
    input logic [OBS_TYPE_BITS-1:0]  typ,
    input logic [OBS_LANE_BITS-1:0]  lane,
    input logic [OBS_DEPTH_BITS-1:0] depth
  );
    logic [OBS_BITS-1:0] word;
    word = '0;
    word[OBS_TYPE_LSB  +: OBS_TYPE_BITS]  = typ;
    word[OBS_LANE_LSB  +: OBS_LANE_BITS]  = lane;
    word[OBS_DEPTH_LSB +: OBS_DEPTH_BITS] = depth;
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_streamer_row_fifo.sv
`default_nettype none
// ============================================================================
// Module      : row_fifo
// Description : ROWS-deep ring buffer of half-block rows with push, pop,
//               occupancy count, sticky underflow and random read by row.
// Revision    : 1.0 - initial release
// ============================================================================
module row_fifo
  import obstacle_streamer_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int WIDTH = ROW_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  output logic [WIDTH-1:0]          rd_data,
  output logic [$clog2(ROWS):0]     count,
  output logic                      underflow
);

  localparam int c_PTR_W = $clog2(ROWS);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   r_mem [ROWS];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic               r_underflow;
  logic [c_PTR_W-1:0] w_rd_idx;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_tail] <= push_data;
    end
  end

  // The caller never pushes and pops in the same cycle; push takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (push) begin
      r_tail  <= r_tail + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(1);
    end else if (pop) begin
      if (r_count == '0) begin
        r_underflow <= 1'b1;
      end else begin
        r_head  <= r_head + c_PTR_W'(1);
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  assign w_rd_idx  = r_head + rd_row;
  assign rd_data   = r_mem[w_rd_idx];
  assign count     = r_count;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: rtl/obstacle_streamer.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_streamer
// Description : Buffers generator rows and, once per frame, streams every
//               (row, lane) entry as an obstacle word, then advances progress.
//               Define SKIP_EMPTY_EN to suppress pulses for empty entries.
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_streamer
  import obstacle_streamer_pkg::*;
#(
  parameter int HALF_BLOCK_LENGTH = 64,
  parameter int ROWS              = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 new_frame,
  input  logic [3:0]                           speed,
  input  logic                                 game_over,
  input  logic [11:0]                          row_data,
  input  logic                                 row_valid,
  output logic                                 row_ready,
  output logic [15:0]                          obstacle,
  output logic                                 obstacle_valid,
  output logic                                 firstrow,
  output logic [$clog2(HALF_BLOCK_LENGTH)-1:0] half_block_progress,
  output logic [$clog2(ROWS):0]                rows_buffered,
  output logic                                 scan_busy,
  output logic                                 underflow
);

  localparam int c_PROG_W = $clog2(HALF_BLOCK_LENGTH);
  localparam int c_PTR_W  = $clog2(ROWS);
  localparam int c_CNT_W  = c_PTR_W + 1;

  state_e              r_state;
  logic [c_PTR_W-1:0]  r_scan_row;
  logic [1:0]          r_scan_lane;
  logic [c_PROG_W-1:0] r_progress;
  logic                r_row_ready;
  logic [15:0]         r_obstacle;
  logic                r_obstacle_valid;
  logic                r_firstrow;
  logic                r_scan_busy;

  logic [ROW_BITS-1:0] w_rd_data;
  logic [c_CNT_W-1:0]  w_count;
  logic [c_CNT_W-1:0]  w_count_next;
  logic                w_underflow;
  logic                w_push;
  logic                w_pop;
  logic                w_advance;
  logic [8:0]          w_prog_sum;
  logic                w_wrap;
  logic                w_last_visit;
  logic                w_row_live;
  logic [3:0]          w_entry;
  logic [10:0]         w_depth;
  logic                w_emit;
  state_e              w_state_next;

  row_fifo #(
    .ROWS  (ROWS),
    .WIDTH (ROW_BITS)
  ) u_row_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (row_data),
    .pop       (w_pop),
    .rd_row    (r_scan_row),
    .rd_data   (w_rd_data),
    .count     (w_count),
    .underflow (w_underflow)
  );

  assign w_push     = row_valid & r_row_ready;
  assign w_advance  = (r_state == ADVANCE) && !game_over;
  assign w_prog_sum = 9'(r_progress) + 9'(speed);
  assign w_wrap     = w_prog_sum >= 9'(HALF_BLOCK_LENGTH);
  assign w_pop      = w_advance && w_wrap;

  assign w_last_visit = (r_state == SCAN) &&
                        (r_scan_row == c_PTR_W'(ROWS - 1)) &&
                        (r_scan_lane == 2'd2);

  always_comb begin
    w_count_next = w_count;
    if (w_push) begin
      w_count_next = w_count + c_CNT_W'(1);
    end else if (w_pop && (w_count != '0)) begin
      w_count_next = w_count - c_CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (new_frame) w_state_next = SCAN;
      SCAN:    if (w_last_visit) w_state_next = ADVANCE;
      ADVANCE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Rows beyond the buffered count read back as empty regardless of memory.
  assign w_row_live = {1'b0, r_scan_row} < w_count;

  always_comb begin
    w_entry = '0;
    case (r_scan_lane)
      2'd0:    w_entry = w_rd_data[3:0];
      2'd1:    w_entry = w_rd_data[7:4];
      default: w_entry = w_rd_data[11:8];
    endcase
    if (!w_row_live) begin
      w_entry = '0;
    end
  end

  assign w_depth = 11'(r_scan_row) * 11'(HALF_BLOCK_LENGTH) +
                   (w_entry[3] ? 11'(RAMP_FIRST_OFFSET) : 11'd0);

`ifdef SKIP_EMPTY_EN
  assign w_emit = (r_state == SCAN) && (w_entry[2:0] != EMPTY);
`else
  assign w_emit = (r_state == SCAN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_scan_row       <= '0;
      r_scan_lane      <= '0;
      r_progress       <= '0;
      r_row_ready      <= 1'b0;
      r_obstacle       <= '0;
      r_obstacle_valid <= 1'b0;
      r_firstrow       <= 1'b0;
      r_scan_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_scan_busy <= (w_state_next != IDLE);
      r_row_ready <= (w_state_next == IDLE) && (w_count_next < c_CNT_W'(ROWS));

      if (r_state == SCAN) begin
        if (r_scan_lane == 2'd2) begin
          r_scan_lane <= 2'd0;
          r_scan_row  <= r_scan_row + c_PTR_W'(1);
        end else begin
          r_scan_lane <= r_scan_lane + 2'd1;
        end
      end else begin
        r_scan_lane <= 2'd0;
        r_scan_row  <= '0;
      end

      r_obstacle_valid <= w_emit;
      r_firstrow       <= w_emit && (r_scan_row == '0);
      if (w_emit) begin
        r_obstacle <= pack_obstacle(w_entry[2:0], r_scan_lane, w_depth);
      end

      if (w_advance) begin
        r_progress <= w_wrap ? '0 : w_prog_sum[c_PROG_W-1:0];
      end
    end
  end

  assign row_ready           = r_row_ready;
  assign obstacle            = r_obstacle;
  assign obstacle_valid      = r_obstacle_valid;
  assign firstrow            = r_firstrow;
  assign half_block_progress = r_progress;
  assign rows_buffered       = w_count;
  assign scan_busy           = r_scan_busy;
  assign underflow           = w_underflow;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_streamer
// Description : Directed self-checking bench for obstacle_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_streamer;

  localparam int HBL  = 64;
  localparam int ROWS = 8;
`ifdef SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_frame;
  logic [3:0]  speed;
  logic        game_over;
  logic [11:0] row_data;
  logic        row_valid;
  logic        row_ready;
  logic [15:0] obstacle;
  logic        obstacle_valid;
  logic        firstrow;
  logic [5:0]  half_block_progress;
  logic [3:0]  rows_buffered;
  logic        scan_busy;
  logic        underflow;

  always #5 clk = ~clk;

  obstacle_streamer #(
    .HALF_BLOCK_LENGTH (HBL),
    .ROWS              (ROWS)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .new_frame           (new_frame),
    .speed               (speed),
    .game_over           (game_over),
    .row_data            (row_data),
    .row_valid           (row_valid),
    .row_ready           (row_ready),
    .obstacle            (obstacle),
    .obstacle_valid      (obstacle_valid),
    .firstrow            (firstrow),
    .half_block_progress (half_block_progress),
    .rows_buffered       (rows_buffered),
    .scan_busy           (scan_busy),
    .underflow           (underflow)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [16:0] cap[$];
  logic [11:0] model_rows[$];
  int          model_prog;
  bit          model_uflow;
  int          busy_cycles;

  always @(negedge clk) begin
    if (obstacle_valid === 1'b1) cap.push_back({firstrow, obstacle});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; new_frame = 1'b0; row_valid = 1'b0; row_data = '0;
    speed = '0; game_over = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_row_ready", row_ready, 0);
    check("rst_valid", obstacle_valid, 0);
    check("rst_rows", rows_buffered, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_uflow", underflow, 0);
    check("rst_prog", half_block_progress, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", row_ready, 1);
    model_rows.delete(); model_prog = 0; model_uflow = 0; cap.delete();
  endtask

  task automatic push_row(input logic [11:0] d);
    int g = 0;
    while (!row_ready && g < 50) begin @(negedge clk); g++; end
    check("push_ready", row_ready, 1);
    row_valid = 1'b1; row_data = d;
    @(negedge clk);
    row_valid = 1'b0;
    model_rows.push_back(d);
  endtask

  task automatic check_scan();
    logic [16:0] exp_q[$];
    logic [11:0] row;
    logic [3:0]  nib;
    for (int r = 0; r < ROWS; r++) begin
      for (int l = 0; l < 3; l++) begin
        row = (r < model_rows.size()) ? model_rows[r] : 12'h000;
        nib = row[4*l +: 4];
        if (SKIP && nib[2:0] == 3'b000) continue;
        exp_q.push_back({(r == 0), nib[2:0], 2'(l), 11'(r * HBL + (nib[3] ? 256 : 0))});
      end
    end
    check("pulse_count", cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      check($sformatf("pulse%0d", i), 32'(cap[i]), 32'(exp_q[i]));
  endtask

  task automatic run_frame(input bit extra);
    int guard = 0;
    logic [11:0] tmp;
    cap.delete(); busy_cycles = 0;
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    while (scan_busy && guard < 200) begin
      busy_cycles++;
      new_frame = (extra && busy_cycles == 5);
      @(negedge clk);
      guard++;
    end
    new_frame = 1'b0;
    check("busy_cycles", busy_cycles, 25);
    check_scan();
    if (!game_over) begin
      if (model_prog + speed < HBL) model_prog += speed;
      else begin
        model_prog = 0;
        if (model_rows.size() > 0) tmp = model_rows.pop_front();
        else model_uflow = 1;
      end
    end
    check("progress", half_block_progress, model_prog);
    check("rows_buffered", rows_buffered, model_rows.size());
    check("underflow", underflow, model_uflow);
    check("ready_after", row_ready, model_rows.size() < ROWS);
    if (extra) begin
      repeat (3) @(negedge clk);
      check("no_retrigger", scan_busy, 0);
    end
  endtask

  initial begin
    logic [16:0] v;
    int idx;

    // Three rows, one obstacle each, plus a mid-scan new_frame that must be ignored
    do_reset();
    push_row(12'h001); push_row(12'h020); push_row(12'h400);
    check("three_rows", rows_buffered, 3);
    run_frame(1'b1);
    idx = SKIP ? 0 : 0; v = (cap.size() > idx) ? cap[idx] : '1;
    check("obs_row0", 32'(v), 32'h1_2000);
    idx = SKIP ? 1 : 4; v = (cap.size() > idx) ? cap[idx] : '1;
    check("obs_row1", 32'(v), 32'h0_4840);
    idx = SKIP ? 2 : 8; v = (cap.size() > idx) ? cap[idx] : '1;
    check("obs_row2", 32'(v), 32'h0_9080);

    // Progress stepping by 4 with a single pop after 16 frames
    do_reset();
    push_row(12'h123); push_row(12'h456);
    speed = 4'd4;
    for (int f = 0; f < 16; f++) run_frame(1'b0);
    check("prog_wrapped", half_block_progress, 0);
    check("one_pop", rows_buffered, 1);

    // Ramp-first entry in lane 1 of row 0
    do_reset();
    push_row(12'h0D0);
    run_frame(1'b0);
    idx = SKIP ? 0 : 1; v = (cap.size() > idx) ? cap[idx] : '1;
    check("ramp_obs", 32'(v), 32'h1_A900);

    // Full buffer refuses a ninth row until a pop frees a slot
    do_reset();
    for (int i = 0; i < ROWS; i++) push_row(12'(i * 12'h111 + 12'h001));
    check("full_rows", rows_buffered, 8);
    check("full_not_ready", row_ready, 0);
    row_valid = 1'b1; row_data = 12'hFFF;
    repeat (3) @(negedge clk);
    row_valid = 1'b0;
    check("ninth_rejected", rows_buffered, 8);
    speed = 4'd15;
    for (int f = 0; f < 5; f++) run_frame(1'b0);
    check("after_pop_rows", rows_buffered, 7);
    check("after_pop_ready", row_ready, 1);

    // Popping an empty buffer sets the sticky underflow
    do_reset();
    speed = 4'd15;
    for (int f = 0; f < 5; f++) run_frame(1'b0);
    check("uflow_set", underflow, 1);
    check("uflow_rows", rows_buffered, 0);

    // game_over freezes progress and the buffer but not the scan
    do_reset();
    push_row(12'h031); push_row(12'h502);
    speed = 4'd4;
    run_frame(1'b0); run_frame(1'b0);
    game_over = 1'b1;
    for (int f = 0; f < 5; f++) run_frame(1'b0);
    game_over = 1'b0;
    check("go_prog", half_block_progress, 8);
    check("go_rows", rows_buffered, 2);

    // Asynchronous reset in the middle of a scan
    do_reset();
    push_row(12'h001); push_row(12'h020); push_row(12'h400);
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    repeat (9) @(negedge clk);
    check("midscan_busy", scan_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", obstacle_valid, 0);
    check("midrst_rows", rows_buffered, 0);
    check("midrst_busy", scan_busy, 0);
    check("midrst_ready", row_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
    repeat (40) @(negedge clk);
    check("no_pulses_after", cap.size(), 0);
    check("rows_after_rst", rows_buffered, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obstacle_streamer.md
OBSTACLE_STREAMER -- requirements
Module: obstacle_streamer

Interface
REQ-001 SHALL have parameter HALF_BLOCK_LENGTH, default 64, meaning the length of one half-block row in score points (power of two, at most 128).
REQ-002 SHALL have parameter ROWS, default 8, meaning ring-buffer depth in half-block rows (power of two, at most 16).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port new_frame, input, 1 bit: one-cycle frame-start pulse.
REQ-006 SHALL have port speed, input, 4 bits: score points advanced per frame.
REQ-007 SHALL have port game_over, input, 1 bit: freezes progress when high.
REQ-008 SHALL have port row_data, input, 12 bits: lane L entry in bits [4L+3:4L], with {ramp_first, type[2:0]}.
REQ-009 SHALL have ports row_valid (input, 1 bit) and row_ready (output, 1 bit): generator handshake.
REQ-010 SHALL have port obstacle, output, 16 bits: {type[2:0], lane[1:0], depth[10:0]}.
REQ-011 SHALL have ports obstacle_valid and firstrow, output, 1 bit each: entry strobe; firstrow marks row 0.
REQ-012 SHALL have port half_block_progress, output, $clog2(HALF_BLOCK_LENGTH) bits: position within row 0.
REQ-013 SHALL have ports rows_buffered (output, $clog2(ROWS)+1 bits), scan_busy (output, 1 bit) and underflow (output, 1 bit, sticky).

Function
REQ-014 SHALL implement states IDLE, SCAN and ADVANCE; a new_frame pulse in IDLE SHALL move to SCAN on the next cycle.
REQ-015 SHALL assert row_ready only in IDLE with rows_buffered < ROWS; when row_valid and row_ready are both high, it SHALL write row_data at the tail and increment rows_buffered.
REQ-016 In SCAN, SHALL visit one (row r, lane L) entry per cycle, r = 0..ROWS-1 outer and L = 0..2 inner, for a fixed 3*ROWS cycles.
REQ-017 Rows with r >= rows_buffered SHALL be treated as all type 000.
REQ-018 A visited entry SHALL drive obstacle_valid high for exactly that cycle, registered, with one-cycle latency from the visit.
REQ-019 The emitted depth SHALL equal r*HALF_BLOCK_LENGTH + (ramp_first ? 256 : 0), truncated to 11 bits.
REQ-020 firstrow SHALL equal (r == 0) while obstacle_valid is high, and 0 otherwise.
REQ-021 There SHALL be no backpressure: obstacle_valid is never held.
REQ-022 After the last visit, SHALL spend one cycle in ADVANCE, then return to IDLE.
REQ-023 In ADVANCE with game_over low: if progress < HALF_BLOCK_LENGTH - speed, progress SHALL increment by speed; otherwise progress SHALL become 0 and row 0 SHALL be popped.
REQ-024 A pop SHALL advance the head with modulo-ROWS wrap and decrement rows_buffered.
REQ-025 A pop with rows_buffered == 0 SHALL leave the count at 0 and set underflow.
REQ-026 In ADVANCE with game_over high, progress and the buffer SHALL be unchanged.
REQ-027 A new_frame pulse during SCAN or ADVANCE SHALL be ignored.
REQ-028 scan_busy SHALL be high in SCAN and ADVANCE.
REQ-029 Since push occurs only in IDLE and pop only in ADVANCE, push and pop SHALL never coincide.

Reset
REQ-030 While rst_n is low, SHALL force state IDLE, head, tail, rows_buffered, progress, underflow, obstacle, obstacle_valid, firstrow and row_ready to 0 immediately, including mid-scan.
REQ-031 Buffer contents SHALL not be reset.

Configuration
REQ-032 With SKIP_EMPTY_EN defined, entries with type 000 SHALL produce no obstacle_valid pulse.
REQ-033 Without SKIP_EMPTY_EN, every visited entry SHALL pulse obstacle_valid, including type 000.
REQ-034 Scan length and timing SHALL be identical with and without SKIP_EMPTY_EN.

Structure
REQ-035 A shared package SHALL hold the obstacle type codes (EMPTY=000, LOW=001, HIGH=010, MID=011, TRAIN=100, RAMP=101, MOVING=110), the RAMP_FIRST_OFFSET=256 constant, and the obstacle field-position constants.
REQ-036 A sub-module row_fifo SHALL implement the ROWS-deep ring buffer with push, pop, count and random read by row index.

Verification
REQ-037 Reset, then push rows 0x001, 0x020, 0x400, then pulse new_frame -> with SKIP_EMPTY_EN: 3 pulses, obstacle 0x2000 with firstrow=1, 0x4840 with firstrow=0, 0x9080 with firstrow=0; scan_busy high for 25 cycles.
REQ-038 speed=4, HALF_BLOCK_LENGTH=64, 16 frames with 2 rows buffered -> progress 0,4,...,60,0; one pop; rows_buffered 2->1.
REQ-039 Ramp entry 0xD in lane 1 of row 0 -> obstacle 0xA900.
REQ-040 Fill 8 rows -> row_ready low and a ninth row_valid is not accepted; after a pop, row_ready returns high in IDLE.
REQ-041 Hold game_over high across 5 frames -> progress constant, no pop, scan output still emitted.
REQ-042 Assert rst_n low at SCAN cycle 10 -> obstacle_valid is 0 immediately; rows_buffered is 0 and no further pulses occur after release.
